// File: rtl/plab5_mcore_proc_resp_acc_pkg.sv
// Shared definitions for the processor response access-control stage:
// mem response field layout, level comparison and drop-mode constants.
package plab5_mcore_proc_resp_acc_pkg;

  localparam int ACC_DROP     = 0;
  localparam int ACC_SANITIZE = 1;

  localparam int MEM_RESP_TYPE_NBITS = 3;

  // Mem response layout, MSB to LSB: {type, opaque, len, data}
  function automatic int mem_resp_len_nbits(input int d);
    return $clog2(d / 8);
  endfunction

  function automatic int mem_resp_nbits(input int o, input int d);
    return MEM_RESP_TYPE_NBITS + o + mem_resp_len_nbits(d) + d;
  endfunction

  function automatic int mem_resp_data_lsb();
    return 0;
  endfunction

  function automatic int mem_resp_len_lsb(input int d);
    return d;
  endfunction

  function automatic int mem_resp_opaque_lsb(input int d);
    return d + mem_resp_len_nbits(d);
  endfunction

  function automatic int mem_resp_type_lsb(input int o, input int d);
    return d + mem_resp_len_nbits(d) + o;
  endfunction

  // Read-down only: a source may flow to a destination of equal or higher level
  function automatic logic lvl_allowed(input logic [31:0] src, input logic [31:0] dst);
    return src <= dst;
  endfunction

endpackage

// File: rtl/plab5_mcore_acc_queue.sv
// Generic val/rdy circular queue; deq_drop pops the head without a handshake.
module plab5_mcore_acc_queue
#(
  parameter int p_msg_nbits   = 8,
  parameter int p_num_entries = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  input  logic                   deq_drop,
  output logic [p_msg_nbits-1:0] deq_msg
);

  localparam int ptr_nbits = $clog2(p_num_entries);
  localparam int cnt_nbits = ptr_nbits + 1;

  logic [p_msg_nbits-1:0] mem [p_num_entries];
  logic [ptr_nbits-1:0]   enq_ptr_reg;
  logic [ptr_nbits-1:0]   deq_ptr_reg;
  logic [cnt_nbits-1:0]   count_reg;

  logic full;
  logic empty;
  logic do_enq;
  logic do_deq;

  assign full    = (count_reg == cnt_nbits'(p_num_entries));
  assign empty   = (count_reg == '0);
  assign enq_rdy = !full;
  assign deq_val = !empty;
  assign deq_msg = mem[deq_ptr_reg];

  // A dequeue in the same cycle never frees space for a full-queue enqueue
  assign do_enq = enq_val && !full;
  assign do_deq = !empty && (deq_rdy || deq_drop);

  // Depth is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
      count_reg   <= '0;
    end else begin
      if (do_enq)
        enq_ptr_reg <= enq_ptr_reg + ptr_nbits'(1);
      if (do_deq)
        deq_ptr_reg <= deq_ptr_reg + ptr_nbits'(1);
      if (do_enq && !do_deq)
        count_reg <= count_reg + cnt_nbits'(1);
      else if (!do_enq && do_deq)
        count_reg <= count_reg - cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq)
      mem[enq_ptr_reg] <= enq_msg;
  end

endmodule

// File: rtl/plab5_mcore_proc_resp_acc_q.sv
// Buffered read-down access check between the network response port and the
// processor memory-response port, with a saturating violation counter.
module plab5_mcore_proc_resp_acc_q
  import plab5_mcore_proc_resp_acc_pkg::*;
#(
  parameter  int p_opaque_nbits = 8,
  parameter  int p_data_nbits   = 32,
  parameter  int p_lvl_nbits    = 2,
  parameter  int p_num_entries  = 2,
  parameter  int p_drop_mode    = 0,
  parameter  int p_cnt_nbits    = 8,
  localparam int resp_nbits     = mem_resp_nbits(p_opaque_nbits, p_data_nbits)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_lvl_nbits-1:0] resp_sec_level,
  input  logic [p_lvl_nbits-1:0] proc_sec_level,
  input  logic                   net_resp_val,
  output logic                   net_resp_rdy,
  input  logic [resp_nbits-1:0]  net_resp_msg,
  output logic                   proc_resp_val,
  input  logic                   proc_resp_rdy,
  output logic [resp_nbits-1:0]  proc_resp_msg,
  input  logic                   viol_clr,
  output logic [p_cnt_nbits-1:0] viol_count,
  output logic                   viol_flag
);

  localparam int  entry_nbits   = resp_nbits + p_lvl_nbits;
  localparam logic sanitize_mode = (p_drop_mode == ACC_SANITIZE);
  localparam logic [p_cnt_nbits+1:0] cnt_max = {2'b00, {p_cnt_nbits{1'b1}}};

  function automatic logic [resp_nbits-1:0] sanitize(input logic [resp_nbits-1:0] m);
    return {m[resp_nbits-1:p_data_nbits], {p_data_nbits{1'b0}}};
  endfunction

  logic                   q_enq_val;
  logic                   q_enq_rdy;
  logic                   q_deq_val;
  logic                   q_deq_rdy;
  logic                   q_deq_drop;
  logic [entry_nbits-1:0] q_deq_entry;
  logic [resp_nbits-1:0]  enq_msg;
  logic [p_lvl_nbits-1:0] enq_tag;
  logic [resp_nbits-1:0]  head_msg;
  logic [p_lvl_nbits-1:0] head_tag;

  logic net_fire;
  logic enq_allowed;
  logic enq_viol;
  logic head_ok;
  logic deq_viol;

  // Enqueue side: disallowed responses are consumed, then dropped or sanitised
  assign net_resp_rdy = q_enq_rdy && !reset;
  assign net_fire     = net_resp_val && net_resp_rdy;
  assign enq_allowed  = lvl_allowed(32'(resp_sec_level), 32'(proc_sec_level));
  assign enq_viol     = net_fire && !enq_allowed;
  assign q_enq_val    = net_fire && (enq_allowed || sanitize_mode);
  assign enq_msg      = enq_allowed ? net_resp_msg : sanitize(net_resp_msg);
  assign enq_tag      = enq_allowed ? resp_sec_level : proc_sec_level;

  plab5_mcore_acc_queue #(
    .p_msg_nbits   (entry_nbits),
    .p_num_entries (p_num_entries)
  ) queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (q_enq_val),
    .enq_rdy  (q_enq_rdy),
    .enq_msg  ({enq_msg, enq_tag}),
    .deq_val  (q_deq_val),
    .deq_rdy  (q_deq_rdy),
    .deq_drop (q_deq_drop),
    .deq_msg  (q_deq_entry)
  );

  // Dequeue side: the processor level may have dropped since enqueue
  assign {head_msg, head_tag} = q_deq_entry;
  assign head_ok       = lvl_allowed(32'(head_tag), 32'(proc_sec_level));
  assign proc_resp_val = !reset && q_deq_val && (head_ok || sanitize_mode);
  assign proc_resp_msg = head_ok ? head_msg : sanitize(head_msg);
  assign q_deq_rdy     = proc_resp_val && proc_resp_rdy;
  assign q_deq_drop    = !sanitize_mode && q_deq_val && !head_ok;
  assign deq_viol      = q_deq_val && !head_ok && (sanitize_mode ? proc_resp_rdy : 1'b1);

  logic [1:0]             viol_n;
  logic [p_cnt_nbits+1:0] cnt_sum;
  logic [p_cnt_nbits-1:0] viol_count_reg;
  logic [p_cnt_nbits-1:0] viol_count_next;
  logic                   viol_flag_reg;
  logic                   viol_flag_next;

  // Clear applies first, so a violation in the clear cycle still counts
  assign viol_n          = {1'b0, enq_viol} + {1'b0, deq_viol};
  assign cnt_sum         = (viol_clr ? '0 : {2'b00, viol_count_reg}) + {{p_cnt_nbits{1'b0}}, viol_n};
  assign viol_count_next = (cnt_sum > cnt_max) ? cnt_max[p_cnt_nbits-1:0] : cnt_sum[p_cnt_nbits-1:0];
  assign viol_flag_next  = (viol_clr ? 1'b0 : viol_flag_reg) | (viol_n != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_count_reg <= '0;
      viol_flag_reg  <= 1'b0;
    end else begin
      viol_count_reg <= viol_count_next;
      viol_flag_reg  <= viol_flag_next;
    end
  end

  assign viol_count = viol_count_reg;
  assign viol_flag  = viol_flag_reg;

endmodule

// File: tb/tb_plab5_mcore_proc_resp_acc_q.sv
// Drives a discard-mode and a sanitise-mode instance with shared stimulus and
// compares both against a queue-based reference model.
module tb_plab5_mcore_proc_resp_acc_q;

  localparam int RN = 45;
  localparam int N  = 2;

  typedef struct packed {
    logic [RN-1:0] msg;
    logic [1:0]    tag;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    resp_sec_level;
  logic [1:0]    proc_sec_level;
  logic          net_resp_val;
  logic [RN-1:0] net_resp_msg;
  logic          proc_resp_rdy;
  logic          viol_clr;

  logic          rdy_o  [2];
  logic          val_o  [2];
  logic [RN-1:0] msg_o  [2];
  logic          flag_o [2];
  logic [7:0]    cnt_o  [2];
  logic [1:0]    cnt0;

  always #5 clk = ~clk;

  plab5_mcore_proc_resp_acc_q #(.p_drop_mode(0), .p_cnt_nbits(2)) dut0 (
    .clk(clk), .reset(reset),
    .resp_sec_level(resp_sec_level), .proc_sec_level(proc_sec_level),
    .net_resp_val(net_resp_val), .net_resp_rdy(rdy_o[0]), .net_resp_msg(net_resp_msg),
    .proc_resp_val(val_o[0]), .proc_resp_rdy(proc_resp_rdy), .proc_resp_msg(msg_o[0]),
    .viol_clr(viol_clr), .viol_count(cnt0), .viol_flag(flag_o[0])
  );

  plab5_mcore_proc_resp_acc_q #(.p_drop_mode(1), .p_cnt_nbits(8)) dut1 (
    .clk(clk), .reset(reset),
    .resp_sec_level(resp_sec_level), .proc_sec_level(proc_sec_level),
    .net_resp_val(net_resp_val), .net_resp_rdy(rdy_o[1]), .net_resp_msg(net_resp_msg),
    .proc_resp_val(val_o[1]), .proc_resp_rdy(proc_resp_rdy), .proc_resp_msg(msg_o[1]),
    .viol_clr(viol_clr), .viol_count(cnt_o[1]), .viol_flag(flag_o[1])
  );

  always_comb cnt_o[0] = {6'b0, cnt0};

  // Reference model state per instance
  ent_t mq [2][$];
  int   mcnt  [2];
  bit   mflag [2];
  int   cmax  [2] = '{3, 255};
  int   mode  [2] = '{0, 1};
  logic [RN-1:0] dlv0 [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RN-1:0] mk(input logic [2:0] t, input logic [7:0] o,
                                       input logic [1:0] l, input logic [31:0] d);
    return {t, o, l, d};
  endfunction

  function automatic logic [RN-1:0] scrub(input logic [RN-1:0] m);
    return {m[RN-1:32], 32'h0};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mcnt[k]  = 0;
      mflag[k] = 1'b0;
    end
  endfunction

  // One clock: drive inputs, compare outputs with the model, advance the model
  task automatic cycle(input bit v, input logic [RN-1:0] m, input logic [1:0] rl,
                       input logic [1:0] pl, input bit r, input bit c);
    bit full, empty, ok, ev;
    int nv, base;
    logic [RN-1:0] hm;
    @(negedge clk);
    net_resp_val   = v;
    net_resp_msg   = m;
    resp_sec_level = rl;
    proc_sec_level = pl;
    proc_resp_rdy  = r;
    viol_clr       = c;
    #1;
    for (int k = 0; k < 2; k++) begin
      full  = (mq[k].size() == N);
      empty = (mq[k].size() == 0);
      ok    = !empty && (mq[k][0].tag <= pl);
      ev    = !empty && (ok || mode[k] == 1);
      check($sformatf("d%0d_rdy", k), 64'(rdy_o[k]), 64'(!full));
      check($sformatf("d%0d_val", k), 64'(val_o[k]), 64'(ev));
      if (ev) begin
        hm = ok ? mq[k][0].msg : scrub(mq[k][0].msg);
        check($sformatf("d%0d_msg", k), 64'(msg_o[k]), 64'(hm));
        if (r) begin
          $display("d%0d resp %h", k, msg_o[k]);
          if (k == 0) dlv0.push_back(msg_o[0]);
        end
      end
      check($sformatf("d%0d_cnt", k), 64'(cnt_o[k]), 64'(mcnt[k]));
      check($sformatf("d%0d_flag", k), 64'(flag_o[k]), 64'(mflag[k]));
      nv = 0;
      if (!empty) begin
        if (ok) begin
          if (r) void'(mq[k].pop_front());
        end else if (mode[k] == 1) begin
          if (r) begin void'(mq[k].pop_front()); nv++; end
        end else begin
          void'(mq[k].pop_front());
          nv++;
        end
      end
      if (v && !full) begin
        if (rl <= pl) mq[k].push_back('{msg: m, tag: rl});
        else begin
          nv++;
          if (mode[k] == 1) mq[k].push_back('{msg: scrub(m), tag: pl});
        end
      end
      base     = c ? 0 : mcnt[k];
      mcnt[k]  = (base + nv > cmax[k]) ? cmax[k] : base + nv;
      mflag[k] = c ? (nv > 0) : (mflag[k] || nv > 0);
    end
  endtask

  task automatic idle(input logic [1:0] pl, input bit r);
    cycle(1'b0, '0, 2'd0, pl, r, 1'b0);
  endtask

  logic [RN-1:0] ma, mb, mc, md;

  initial begin
    reset = 1'b1;
    net_resp_val = 1'b0; net_resp_msg = '0; resp_sec_level = '0;
    proc_sec_level = '0; proc_resp_rdy = 1'b0; viol_clr = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_d%0d_rdy", k), 64'(rdy_o[k]), 64'd0);
      check($sformatf("rst_d%0d_val", k), 64'(val_o[k]), 64'd0);
      check($sformatf("rst_d%0d_cnt", k), 64'(cnt_o[k]), 64'd0);
      check($sformatf("rst_d%0d_flag", k), 64'(flag_o[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Allowed response passes through unchanged after one cycle
    ma = mk(3'd0, 8'h05, 2'd0, 32'hDEADBEEF);
    cycle(1'b1, ma, 2'd1, 2'd2, 1'b1, 1'b0);
    idle(2'd2, 1'b1);
    check("pass_val", 64'(val_o[0]), 64'd1);
    check("pass_msg", 64'(msg_o[0]), 64'(ma));
    check("pass_cnt", 64'(cnt_o[0]), 64'd0);

    // Higher-level response: discarded by dut0, sanitised by dut1
    cycle(1'b1, ma, 2'd3, 2'd1, 1'b1, 1'b0);
    idle(2'd1, 1'b1);
    check("drop_val", 64'(val_o[0]), 64'd0);
    check("san_msg", 64'(msg_o[1]), 64'(mk(3'd0, 8'h05, 2'd0, 32'h0)));
    repeat (4) idle(2'd1, 1'b1);
    check("drop_cnt", 64'(cnt_o[0]), 64'd1);
    check("san_cnt", 64'(cnt_o[1]), 64'd1);

    // Backpressure: A and B fill the queue, C stalls until space frees
    ma = mk(3'd1, 8'h0A, 2'd1, 32'h0000000A);
    mb = mk(3'd1, 8'h0B, 2'd2, 32'h0000000B);
    mc = mk(3'd1, 8'h0C, 2'd3, 32'h0000000C);
    dlv0.delete();
    cycle(1'b1, ma, 2'd0, 2'd3, 1'b0, 1'b0);
    cycle(1'b1, mb, 2'd0, 2'd3, 1'b0, 1'b0);
    cycle(1'b1, mc, 2'd0, 2'd3, 1'b0, 1'b0);
    check("bp_full", 64'(rdy_o[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, mc, 2'd0, 2'd3, 1'b1, 1'b0);
      if (mq[0].size() == 1 && mq[0][0].msg == mc) break;
    end
    repeat (3) idle(2'd3, 1'b1);
    check("bp_count", 64'(dlv0.size()), 64'd3);
    if (dlv0.size() == 3) begin
      check("bp_a", 64'(dlv0[0]), 64'(ma));
      check("bp_b", 64'(dlv0[1]), 64'(mb));
      check("bp_c", 64'(dlv0[2]), 64'(mc));
    end

    // Re-check at dequeue after the processor level drops
    cycle(1'b0, '0, 2'd0, 2'd3, 1'b1, 1'b1);
    md = mk(3'd0, 8'h0D, 2'd0, 32'h12345678);
    cycle(1'b1, md, 2'd2, 2'd2, 1'b0, 1'b0);
    idle(2'd1, 1'b0);
    idle(2'd1, 1'b0);
    check("rechk_val", 64'(val_o[0]), 64'd0);
    check("rechk_cnt", 64'(cnt_o[0]), 64'd1);

    // Saturation of the 2-bit counter, then clear with a simultaneous drop
    repeat (5) cycle(1'b1, md, 2'd3, 2'd0, 1'b1, 1'b0);
    idle(2'd0, 1'b1);
    check("sat_cnt", 64'(cnt_o[0]), 64'd3);
    cycle(1'b1, md, 2'd3, 2'd0, 1'b1, 1'b1);
    idle(2'd0, 1'b1);
    check("clr_cnt", 64'(cnt_o[0]), 64'd1);
    check("clr_flag", 64'(flag_o[0]), 64'd1);

    // Randomised traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, {$urandom, $urandom},
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      if (i == 700) begin
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
          check($sformatf("mid_d%0d_val", k), 64'(val_o[k]), 64'd0);
          check($sformatf("mid_d%0d_cnt", k), 64'(cnt_o[k]), 64'd0);
          check($sformatf("mid_d%0d_rdy", k), 64'(rdy_o[k]), 64'd0);
        end
        model_reset();
        net_resp_val = 1'b0; proc_resp_rdy = 1'b0; viol_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_proc_resp_acc_q.md
Name: plab5_mcore_proc_resp_acc_q

Overview:
- Buffered, parametrised access-control stage between the network response port and a processor's memory-response port.
- Supports multi-bit security levels; allows read-down only (resp_sec_level <= proc_sec_level).
- Disallowed responses are either discarded or forwarded with data sanitised.
- Re-checks each buffered response against the current processor level at dequeue.
- Counts violations for the core's security monitor.

Parameters:
- p_opaque_nbits, 8, mem response opaque field width
- p_data_nbits, 32, mem response data field width
- p_lvl_nbits, 2, security level width (unsigned; larger = more privileged)
- p_num_entries, 2, queue depth; power of two, >= 2
- p_drop_mode, 0, 0 = discard disallowed response; 1 = forward with data field forced to zero
- p_cnt_nbits, 8, violation counter width
- resp_nbits, `VC_MEM_RESP_MSG_NBITS(o,d)`, derived; not set externally

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- resp_sec_level  in  p_lvl_nbits  level of the response on net_resp_msg
- proc_sec_level  in  p_lvl_nbits  current processor level
- net_resp_val  in  1  network response valid
- net_resp_rdy  out  1  network response ready
- net_resp_msg  in  resp_nbits  network response {type,opaque,len,data}
- proc_resp_val  out  1  processor response valid
- proc_resp_rdy  in  1  processor response ready
- proc_resp_msg  out  resp_nbits  processor response
- viol_clr  in  1  synchronous clear of viol_count and viol_flag
- viol_count  out  p_cnt_nbits  saturating violation count
- viol_flag  out  1  sticky: any violation since last clear/reset

Behaviour:
- Reset (asynchronous, active-high): queue empty, pointers 0, viol_count=0, viol_flag=0.
  - Outputs during reset: proc_resp_val=0, net_resp_rdy=0.
- Queue entry holds {msg, lvl_tag}; lvl_tag = resp_sec_level sampled at enqueue.
- net_resp_rdy = !full.
  - Registered-state dependency only; no combinational path from proc_resp_rdy.
  - No enqueue when full, even if a dequeue occurs in the same cycle.
- Enqueue-side check, on net_resp_val && net_resp_rdy:
  - resp_sec_level <= proc_sec_level: enqueue unchanged.
  - Otherwise, mode 0: message is consumed and not enqueued; counts one violation.
  - Otherwise, mode 1: enqueue with data bits zeroed; type, opaque, len preserved; lvl_tag = proc_sec_level; counts one violation.
- Dequeue-side check each cycle, head entry present:
  - head_ok = (lvl_tag <= proc_sec_level).
  - proc_resp_val = !empty && (head_ok || p_drop_mode==1).
  - proc_resp_msg = head msg, with data zeroed when !head_ok.
  - Mode 1 with !head_ok: entry is forwarded sanitised; counts one violation on handshake.
  - Mode 0 with !head_ok: head pops that cycle without val; counts one violation.
- Latency: minimum 1 cycle, enqueue to proc_resp_val. Order preserved. Full throughput: 1 msg/cycle when not full.
- Simultaneous enqueue and dequeue when not full: both occur; occupancy unchanged.
- Pointers wrap modulo p_num_entries. Full/empty use an occupancy counter of width clog2(p_num_entries)+1.
- Violations per cycle: 0, 1 or 2 (enqueue-side + dequeue-side).
  - viol_count += n, saturating at 2^p_cnt_nbits-1.
  - viol_flag set when n > 0.
- viol_clr in the same cycle as n > 0: count = n (saturated); flag = 1. Clear takes effect before increment.
- X on level inputs while net_resp_val=0 is ignored.
- Level inputs are not registered; they are sampled when used.

Decomposition:
- Shared package/header holds:
  - the mem response field offsets (vc-mem-msgs.v macros)
  - the level compare function lvl_allowed(src, dst)
  - drop-mode constants ACC_DROP=0, ACC_SANITIZE=1
- One sub-module: plab5_mcore_acc_queue.
  - Generic val/rdy circular queue, with payload width and depth parameters.
  - Provides a head-pop-without-handshake input for mode-0 discard.
- Access check and counter live in the top.

Test Plan:
- Pass: resp lvl 1, proc lvl 2, msg opaque 0x05 data 0xDEADBEEF, proc_resp_rdy=1 -> next cycle proc_resp_val=1, msg identical; viol_count=0, viol_flag=0.
- Mode 0 drop: resp lvl 3, proc lvl 1, one message -> net_resp_rdy=1 accepted; proc_resp_val stays 0 for 5 cycles; viol_count=1, viol_flag=1.
- Mode 1 sanitize: same stimulus -> proc_resp_msg has data=0x00000000, opaque 0x05, type/len preserved; viol_count=1.
- Backpressure: depth 2, proc_resp_rdy=0, send A,B,C -> net_resp_rdy low after B, C stalled; release rdy -> A,B,C delivered in order, no loss.
- Re-check: enqueue at resp lvl 2 / proc lvl 2 with proc_resp_rdy=0, then drop proc lvl to 1 -> mode 0: entry popped without val; viol_count=1, queue empty.
- Counter: p_cnt_nbits=2, 5 drops -> viol_count=3; viol_clr with a drop in the same cycle -> 1; assert reset mid-burst -> queue empty, proc_resp_val=0, viol_count=0 immediately.
